// File: rtl/apb_master_bridge_pkg.sv
// Shared definitions for the APB master bridge: FSM state encoding and default widths.
package apb_master_bridge_pkg;

  localparam int DEF_ADDR_SIZE  = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_SEL_BIT    = 10;
  localparam int DEF_TIMEOUT    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP,
    ST_DECERR
  } state_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: picks slave 1 or 2 from one address bit,
// flags any set bit above it as a decode error, and strips the slave offset.
module apb_addr_decode #(
  parameter int ADDR_SIZE = 32,
  parameter int SEL_BIT   = 10
) (
  input  logic [ADDR_SIZE-1:0] addr,
  output logic                 sel1,
  output logic                 sel2,
  output logic                 decerr,
  output logic [ADDR_SIZE-1:0] offset
);

  assign decerr = |addr[ADDR_SIZE-1:SEL_BIT+1];
  assign sel1   = ~decerr & ~addr[SEL_BIT];
  assign sel2   = ~decerr &  addr[SEL_BIT];
  assign offset = {{(ADDR_SIZE-SEL_BIT){1'b0}}, addr[SEL_BIT-1:0]};

endmodule

// File: rtl/apb_master_bridge.sv
// APB master bridge: takes single requests on a valid/ready port, runs one
// SETUP/ACCESS transfer on the decoded slave and returns a one-cycle response.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SEL_BIT    = DEF_SEL_BIT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_SIZE-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_SIZE-1:0]  PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PWRITE,
  output logic                  PSEL1,
  output logic                  PSEL2,
  output logic                  PENABLE,
  input  logic [DATA_WIDTH-1:0] PRDATA1,
  input  logic [DATA_WIDTH-1:0] PRDATA2,
  input  logic                  PREADY1,
  input  logic                  PREADY2
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  dec_sel1;
  logic                  dec_sel2;
  logic                  dec_err;
  logic [ADDR_SIZE-1:0]  dec_offset;
  logic                  sel1_q;
  logic                  sel2_q;
  logic [ADDR_SIZE-1:0]  paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  accept;
  logic                  pready_sel;
  logic [DATA_WIDTH-1:0] prdata_sel;
  logic                  timeout;

  apb_addr_decode #(
    .ADDR_SIZE (ADDR_SIZE),
    .SEL_BIT   (SEL_BIT)
  ) u_decode (
    .addr   (req_addr),
    .sel1   (dec_sel1),
    .sel2   (dec_sel2),
    .decerr (dec_err),
    .offset (dec_offset)
  );

  assign accept     = (state == ST_IDLE) && req_valid;
  assign pready_sel = sel2_q ? PREADY2 : PREADY1;
  assign prdata_sel = sel2_q ? PRDATA2 : PRDATA1;
  assign timeout    = (wait_cnt == LAST_WAIT);

  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // State register; reset drops the bus immediately since outputs decode from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and bus/handshake outputs; ready is held low while in reset.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    PSEL1      = 1'b0;
    PSEL2      = 1'b0;
    PENABLE    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = rst_n;
        if (req_valid) begin
          state_next = dec_err ? ST_DECERR : ST_SETUP;
        end
      end
      ST_SETUP: begin
        PSEL1      = sel1_q;
        PSEL2      = sel2_q;
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        PSEL1   = sel1_q;
        PSEL2   = sel2_q;
        PENABLE = 1'b1;
        if (pready_sel || timeout) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      ST_DECERR: begin
        rsp_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Wait-state counter: counts ACCESS cycles, cleared whenever not in ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == ST_ACCESS) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Request latches and response data; response regs hold until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel1_q   <= 1'b0;
      sel2_q   <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      sel1_q   <= dec_sel1;
      sel2_q   <= dec_sel2;
      paddr_q  <= dec_offset;
      pwdata_q <= req_wdata;
      pwrite_q <= req_write;
      if (dec_err) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end else if (state == ST_ACCESS) begin
      if (pready_sel) begin
        rdata_q <= pwrite_q ? '0 : prdata_sel;
        err_q   <= 1'b0;
      end else if (timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

endmodule
